// File: rtl/pc_defs_pkg.sv
// Shared definitions for the program-counter unit.
//   STEP_ARM / STEP_THUMB : instruction widths in bytes for each state
//   pc_state_e            : fill/run state of the fetch-decode-execute slots
//   vec_idx_e             : exception vector indices (vector = base + idx*4)
package pc_defs;

    localparam int unsigned STEP_ARM   = 4;
    localparam int unsigned STEP_THUMB = 2;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } pc_state_e;

    typedef enum logic [2:0] {
        VEC_RST  = 3'd0,
        VEC_UND  = 3'd1,
        VEC_SWI  = 3'd2,
        VEC_PABT = 3'd3,
        VEC_DABT = 3'd4,
        VEC_IRQ  = 3'd5,
        VEC_FIQ  = 3'd6
    } vec_idx_e;

endpackage

// File: rtl/pc_incr.sv
// AW-bit address incrementer: o_sum = i_op + i_step, modulo 2^AW.
// Ports:
//   i_op   AW  base address
//   i_step 4   byte increment (2, 4 or 8)
//   o_sum  AW  result, wraps silently
module pc_incr #(
    parameter int AW = 32
) (
    input  logic [AW-1:0] i_op,
    input  logic [3:0]    i_step,
    output logic [AW-1:0] o_sum
);

    assign o_sum = i_op + {{(AW-4){1'b0}}, i_step};

endmodule

// File: rtl/pc_pipe.sv
// Program-counter unit: fetch PC plus the addresses and valid bits of the
// instructions in decode and execute, with flush on redirect/exception.
// Optional feature macro: PC_THUMB_EN (adds Thumb state and the o_thumb port).
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   en                 advance one instruction (0 = stall)
//   i_redirect_en/addr branch or PC write from execute
//   i_exc_en/idx       take exception to vector idx
//   o_fetch_pc/valid   fetch address and its valid
//   o_dec_pc/valid     decode slot address and valid
//   o_exe_pc/valid     execute slot address and valid
//   o_pc_read          execute address + 2 instruction widths
//   o_link             execute address + 1 instruction width
//   o_pc_next          fetch address + 1 instruction width
//   o_thumb            Thumb state (PC_THUMB_EN only)
//   o_state            debug view of the FILL/RUN state
// Control priority per edge: exception > redirect > en > hold.
module pc_pipe
    import pc_defs::*;
#(
    parameter int            AW        = 32,
    parameter logic [AW-1:0] RESET_VEC = '0,
    parameter logic [AW-1:0] VEC_BASE  = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          i_redirect_en,
    input  logic [AW-1:0] i_redirect_addr,
    input  logic          i_exc_en,
    input  logic [2:0]    i_exc_idx,
    output logic [AW-1:0] o_fetch_pc,
    output logic          o_fetch_valid,
    output logic [AW-1:0] o_dec_pc,
    output logic          o_dec_valid,
    output logic [AW-1:0] o_exe_pc,
    output logic          o_exe_valid,
    output logic [AW-1:0] o_pc_read,
    output logic [AW-1:0] o_link,
    output logic [AW-1:0] o_pc_next,
`ifdef PC_THUMB_EN
    output logic          o_thumb,
`endif
    output logic          o_state
);

    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic          fetch_valid_q;
    logic [AW-1:0] dec_pc_q, dec_pc_d;
    logic          dec_valid_q, dec_valid_d;
    logic [AW-1:0] exe_pc_q, exe_pc_d;
    logic          exe_valid_q, exe_valid_d;
    pc_state_e     state_q, state_d;
    logic [3:0]    fetch_step, exe_step;

`ifdef PC_THUMB_EN
    // Each slot carries the state it was fetched in, so link/pc-read use the
    // width of the instruction actually in execute.
    logic thumb_q, thumb_d;
    logic dec_thumb_q, dec_thumb_d;
    logic exe_thumb_q, exe_thumb_d;

    assign fetch_step = thumb_q     ? 4'(STEP_THUMB) : 4'(STEP_ARM);
    assign exe_step   = exe_thumb_q ? 4'(STEP_THUMB) : 4'(STEP_ARM);
    assign o_thumb    = thumb_q;
`else
    assign fetch_step = 4'(STEP_ARM);
    assign exe_step   = 4'(STEP_ARM);
`endif

    pc_incr #(.AW(AW)) u_incr_next (.i_op(fetch_pc_q), .i_step(fetch_step),       .o_sum(o_pc_next));
    pc_incr #(.AW(AW)) u_incr_link (.i_op(exe_pc_q),   .i_step(exe_step),         .o_sum(o_link));
    pc_incr #(.AW(AW)) u_incr_read (.i_op(exe_pc_q),   .i_step(exe_step << 1),    .o_sum(o_pc_read));

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        dec_pc_d    = dec_pc_q;
        dec_valid_d = dec_valid_q;
        exe_pc_d    = exe_pc_q;
        exe_valid_d = exe_valid_q;
`ifdef PC_THUMB_EN
        thumb_d     = thumb_q;
        dec_thumb_d = dec_thumb_q;
        exe_thumb_d = exe_thumb_q;
`endif
        if (i_exc_en) begin
            fetch_pc_d  = VEC_BASE + AW'({i_exc_idx, 2'b00});
            dec_valid_d = 1'b0;
            exe_valid_d = 1'b0;
`ifdef PC_THUMB_EN
            thumb_d     = 1'b0;
`endif
        end else if (i_redirect_en) begin
`ifdef PC_THUMB_EN
            // Target bit 0 selects the new state; Thumb keeps halfword alignment.
            thumb_d    = i_redirect_addr[0];
            fetch_pc_d = i_redirect_addr[0] ? {i_redirect_addr[AW-1:1], 1'b0}
                                            : {i_redirect_addr[AW-1:2], 2'b00};
`else
            fetch_pc_d = {i_redirect_addr[AW-1:2], 2'b00};
`endif
            dec_valid_d = 1'b0;
            exe_valid_d = 1'b0;
        end else if (en) begin
            exe_pc_d    = dec_pc_q;
            exe_valid_d = dec_valid_q;
            dec_pc_d    = fetch_pc_q;
            // Fetch is always valid once out of reset.
            dec_valid_d = 1'b1;
            fetch_pc_d  = o_pc_next;
`ifdef PC_THUMB_EN
            exe_thumb_d = dec_thumb_q;
            dec_thumb_d = thumb_q;
`endif
        end
        // RUN exactly when both downstream slots will hold real instructions.
        state_d = (dec_valid_d && exe_valid_d) ? ST_RUN : ST_FILL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_VEC;
            fetch_valid_q <= 1'b0;
            dec_pc_q      <= '0;
            dec_valid_q   <= 1'b0;
            exe_pc_q      <= '0;
            exe_valid_q   <= 1'b0;
            state_q       <= ST_FILL;
`ifdef PC_THUMB_EN
            thumb_q       <= 1'b0;
            dec_thumb_q   <= 1'b0;
            exe_thumb_q   <= 1'b0;
`endif
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            fetch_valid_q <= 1'b1;
            dec_pc_q      <= dec_pc_d;
            dec_valid_q   <= dec_valid_d;
            exe_pc_q      <= exe_pc_d;
            exe_valid_q   <= exe_valid_d;
            state_q       <= state_d;
`ifdef PC_THUMB_EN
            thumb_q       <= thumb_d;
            dec_thumb_q   <= dec_thumb_d;
            exe_thumb_q   <= exe_thumb_d;
`endif
        end
    end

    assign o_fetch_pc    = fetch_pc_q;
    assign o_fetch_valid = fetch_valid_q;
    assign o_dec_pc      = dec_pc_q;
    assign o_dec_valid   = dec_valid_q;
    assign o_exe_pc      = exe_pc_q;
    assign o_exe_valid   = exe_valid_q;
    assign o_state       = logic'(state_q);

endmodule

// File: tb/tb_pc_pipe.sv
// Directed bench for pc_pipe: a 32-bit instance (reset vector 0, vector base 0)
// and a 16-bit instance (vector base 0x100) for wrap-around and vector offset.
// Thumb checks are compiled in when PC_THUMB_EN is defined.
module tb_pc_pipe;
    import pc_defs::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    // 32-bit instance
    logic        a_en = 0, a_redir = 0, a_exc = 0;
    logic [31:0] a_raddr = '0;
    logic [2:0]  a_idx = '0;
    logic [31:0] a_fetch_pc, a_dec_pc, a_exe_pc, a_pc_read, a_link, a_pc_next;
    logic        a_fetch_valid, a_dec_valid, a_exe_valid, a_state;
`ifdef PC_THUMB_EN
    logic        a_thumb;
`endif

    pc_pipe #(.AW(32), .RESET_VEC(32'h0), .VEC_BASE(32'h0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(a_en),
        .i_redirect_en(a_redir), .i_redirect_addr(a_raddr),
        .i_exc_en(a_exc), .i_exc_idx(a_idx),
        .o_fetch_pc(a_fetch_pc), .o_fetch_valid(a_fetch_valid),
        .o_dec_pc(a_dec_pc), .o_dec_valid(a_dec_valid),
        .o_exe_pc(a_exe_pc), .o_exe_valid(a_exe_valid),
        .o_pc_read(a_pc_read), .o_link(a_link), .o_pc_next(a_pc_next),
`ifdef PC_THUMB_EN
        .o_thumb(a_thumb),
`endif
        .o_state(a_state)
    );

    // 16-bit instance
    logic        b_en = 0, b_redir = 0, b_exc = 0;
    logic [15:0] b_raddr = '0;
    logic [2:0]  b_idx = '0;
    logic [15:0] b_fetch_pc, b_dec_pc, b_exe_pc, b_pc_read, b_link, b_pc_next;
    logic        b_fetch_valid, b_dec_valid, b_exe_valid, b_state;
`ifdef PC_THUMB_EN
    logic        b_thumb;
`endif

    pc_pipe #(.AW(16), .RESET_VEC(16'h0040), .VEC_BASE(16'h0100)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(b_en),
        .i_redirect_en(b_redir), .i_redirect_addr(b_raddr),
        .i_exc_en(b_exc), .i_exc_idx(b_idx),
        .o_fetch_pc(b_fetch_pc), .o_fetch_valid(b_fetch_valid),
        .o_dec_pc(b_dec_pc), .o_dec_valid(b_dec_valid),
        .o_exe_pc(b_exe_pc), .o_exe_valid(b_exe_valid),
        .o_pc_read(b_pc_read), .o_link(b_link), .o_pc_next(b_pc_next),
`ifdef PC_THUMB_EN
        .o_thumb(b_thumb),
`endif
        .o_state(b_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int guard;
        logic [31:0] e;

        // Reset state (asynchronous assertion, before any clock edge)
        #1 rst_n = 1'b0;
        #2;
        check("rst_fetch_pc",    a_fetch_pc, 32'h0);
        check("rst_fetch_valid", 32'(a_fetch_valid), 32'h0);
        check("rst_dec_valid",   32'(a_dec_valid), 32'h0);
        check("rst_exe_valid",   32'(a_exe_valid), 32'h0);
        check("rst_exe_pc",      a_exe_pc, 32'h0);
        check("rst_state",       32'(a_state), 32'(ST_FILL));
        check("rst_pc_next",     a_pc_next, 32'h4);
        check("rst_b_fetch_pc",  32'(b_fetch_pc), 32'h40);
        #19 rst_n = 1'b1;

        // 1: fill from reset
        a_en = 1'b1;
        exp_q.push_back(32'h0);  exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);  exp_q.push_back(32'h10);
        e = exp_q.pop_front();
        check("t1_fetch0", a_fetch_pc, e);
        for (int i = 0; i < 4; i++) begin
            tick();
            e = exp_q.pop_front();
            check("t1_fetch_seq", a_fetch_pc, e);
            check("t1_fetch_valid", 32'(a_fetch_valid), 32'h1);
            if (i == 0) begin
                check("t1_dec_valid_first", 32'(a_dec_valid), 32'h1);
                check("t1_exe_valid_not_yet", 32'(a_exe_valid), 32'h0);
                check("t1_state_fill", 32'(a_state), 32'(ST_FILL));
            end
            if (i == 1) begin
                check("t1_exe_valid_at8", 32'(a_exe_valid), 32'h1);
                check("t1_exe_pc_at8", a_exe_pc, 32'h0);
                check("t1_pc_read_at8", a_pc_read, 32'h8);
                check("t1_link_at8", a_link, 32'h4);
                check("t1_state_run", 32'(a_state), 32'(ST_RUN));
            end
        end
        check("t1_dec_pc_end", a_dec_pc, 32'hC);
        check("t1_exe_pc_end", a_exe_pc, 32'h8);

        // 2: redirect with misaligned target
        guard = 0;
        while (a_exe_pc !== 32'h20 && guard < 20) begin
            tick();
            guard++;
        end
        check("t2_reach_exe_20", a_exe_pc, 32'h20);
        check("t2_pc_read", a_pc_read, 32'h28);
        a_redir = 1'b1; a_raddr = 32'h103;
        tick();
        a_redir = 1'b0;
        check("t2_fetch_aligned", a_fetch_pc, 32'h100);
        check("t2_dec_flushed", 32'(a_dec_valid), 32'h0);
        check("t2_exe_flushed", 32'(a_exe_valid), 32'h0);
        check("t2_state_fill", 32'(a_state), 32'(ST_FILL));
        tick();
        check("t2_fetch_104", a_fetch_pc, 32'h104);
        check("t2_state_fill1", 32'(a_state), 32'(ST_FILL));
        tick();
        check("t2_exe_pc_100", a_exe_pc, 32'h100);
        check("t2_exe_valid", 32'(a_exe_valid), 32'h1);
        check("t2_state_run", 32'(a_state), 32'(ST_RUN));

        // 3: exception beats a simultaneous redirect
        a_redir = 1'b1; a_raddr = 32'h40;
        tick();
        a_redir = 1'b0;
        tick(); tick();
        check("t3_exe_pc_40", a_exe_pc, 32'h40);
        a_exc = 1'b1; a_idx = 3'(VEC_SWI);
        a_redir = 1'b1; a_raddr = 32'h300;
        #1;
        check("t3_link_exc_cycle", a_link, 32'h44);
        tick();
        a_exc = 1'b0; a_redir = 1'b0;
        check("t3_fetch_vector", a_fetch_pc, 32'h08);
        check("t3_exe_flushed", 32'(a_exe_valid), 32'h0);
        check("t3_state_fill", 32'(a_state), 32'(ST_FILL));

        // 4: stall holds everything; redirect still acts during stall
        tick(); tick();
        check("t4_pre_fetch", a_fetch_pc, 32'h10);
        a_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_stall_fetch", a_fetch_pc, 32'h10);
            check("t4_stall_dec", a_dec_pc, 32'hC);
            check("t4_stall_exe", a_exe_pc, 32'h8);
            check("t4_stall_read", a_pc_read, 32'h10);
            check("t4_stall_state", 32'(a_state), 32'(ST_RUN));
        end
        a_redir = 1'b1; a_raddr = 32'h55;
        tick();
        a_redir = 1'b0;
        check("t4_stall_redirect", a_fetch_pc, 32'h54);
        check("t4_stall_flush", 32'(a_dec_valid), 32'h0);

`ifdef PC_THUMB_EN
        // 6: Thumb state via redirect bit 0
        a_redir = 1'b1; a_raddr = 32'h201;
        tick();
        a_redir = 1'b0;
        check("t6_thumb_set", 32'(a_thumb), 32'h1);
        check("t6_fetch_200", a_fetch_pc, 32'h200);
        a_en = 1'b1;
        tick();
        check("t6_fetch_202", a_fetch_pc, 32'h202);
        tick();
        check("t6_fetch_204", a_fetch_pc, 32'h204);
        check("t6_exe_pc", a_exe_pc, 32'h200);
        check("t6_pc_read", a_pc_read, 32'h204);
        check("t6_link", a_link, 32'h202);
        a_en = 1'b0;
`endif

        // 5: 16-bit wrap and vector base offset
        b_redir = 1'b1; b_raddr = 16'hFFFE;
        tick();
        b_redir = 1'b0;
        check("t5_b_fetch_fffc", 32'(b_fetch_pc), 32'hFFFC);
        b_en = 1'b1;
        tick();
        b_en = 1'b0;
        check("t5_b_wrap", 32'(b_fetch_pc), 32'h0);
        check("t5_b_dec_pc", 32'(b_dec_pc), 32'hFFFC);
        check("t5_b_dec_valid", 32'(b_dec_valid), 32'h1);
        check("t5_b_exe_valid", 32'(b_exe_valid), 32'h0);
        check("t5_b_pc_next", 32'(b_pc_next), 32'h4);
        b_exc = 1'b1; b_idx = 3'd7;
        tick();
        b_exc = 1'b0;
        check("t5_b_vector7", 32'(b_fetch_pc), 32'h11C);

        // Async reset mid-run, no clock edge needed
        a_en = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst2_fetch_pc", a_fetch_pc, 32'h0);
        check("rst2_exe_valid", 32'(a_exe_valid), 32'h0);
        check("rst2_fetch_valid", 32'(a_fetch_valid), 32'h0);
        check("rst2_b_fetch_pc", 32'(b_fetch_pc), 32'h40);
`ifdef PC_THUMB_EN
        check("rst2_thumb", 32'(a_thumb), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
